fifo_ram: RTL and testbench

Single-clock, RAM-backed 8-bit FIFO with 16384 entries. It buffers byte streams between communication front-ends and their consumers. Reads and writes are gated by a block-level `enable`, and `full`/`empty` flags provide flow control. Read data is registered, and overflow and underflow attempts are silently ignored.

---
 rtl/fifo_ram_pkg.sv | 10 +
 rtl/fifo_ram_mem.sv | 36 +++
 rtl/fifo_ram.sv | 99 +++++++++
 tb/tb_fifo_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_ram_pkg.sv
// Shared sizing for the RAM-backed byte FIFO.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_ram_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 14;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

endpackage : fifo_ram_pkg

// File: rtl/fifo_ram_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset.
// Latency: read data valid one clock after rd_en is sampled.
// Backpressure: none; caller guarantees legal enables.
module fifo_ram_mem
    import fifo_ram_pkg::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    // Storage array; left unreset so it maps onto block RAM.
    logic [DW-1:0] mem [0:(1 << AW)-1];

    // Write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Synchronous read port; output holds between reads.
    always_ff @(posedge clock) begin
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule : fifo_ram_mem

// File: rtl/fifo_ram.sv
// Single-clock RAM-backed byte FIFO, 2^ADDR_WIDTH entries, with full/empty flags.
// Latency: write visible to a read one edge later; read data on data_out one edge after do_read.
// Backpressure: writes dropped while full, reads dropped while empty; block ignores requests when enable=0.
module fifo_ram
    import fifo_ram_pkg::*;
#(
    parameter int DATA_WIDTH = fifo_ram_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fifo_ram_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    input  logic                  write,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    // Count value meaning "every entry occupied" (one bit wider than pointers).
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_write;
    logic                  do_read;
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  out_vld;

    // Requests qualified by enable and the current flags; a blocked side never
    // disturbs the other side.
    assign do_write = enable & write & ~full;
    assign do_read  = enable & read  & ~empty;

    // Flags are decoded from the registered count only.
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Write pointer advances on every accepted write; wraps modulo depth.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
        end else if (do_write) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // Read pointer advances on every accepted read; wraps modulo depth.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
        end else if (do_read) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: up on write only, down on read only, steady on both/neither.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The RAM read register is not resettable, so a reset-cleared marker
    // forces data_out to zero until the first read after reset lands.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_vld <= 1'b0;
        end else if (do_read) begin
            out_vld <= 1'b1;
        end
    end

    assign data_out = out_vld ? ram_q : '0;

    // Read and write never hit the same address in one cycle: a same-address
    // collision needs count 0 (read blocked) or count full (write blocked).
    fifo_ram_mem #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (do_write),
        .wr_addr (wr_ptr),
        .wr_dat  (data_in),
        .rd_en   (do_read),
        .rd_addr (rd_ptr),
        .rd_dat  (ram_q)
    );

endmodule : fifo_ram

// File: tb/tb_fifo_ram.sv
// Directed bench for fifo_ram with hand-computed expectations.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: exercises full/empty drop behaviour and enable gating.
module tb_fifo_ram;

    localparam int DW    = 8;
    localparam int AW    = 14;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          read;
    logic          write;
    logic          enable;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;

    int checks;
    int errors;
    int bad_reads;

    fifo_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data_in  (data_in),
        .read     (read),
        .write    (write),
        .enable   (enable),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        bad_reads = 0;
        reset     = 1'b0;
        data_in   = '0;
        read      = 1'b0;
        write     = 1'b0;
        enable    = 1'b0;

        // Reset state
        step();
        step();
        reset = 1'b1;
        #1;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", data_out, 8'h00);

        // Basic ordering
        enable = 1'b1;
        write = 1'b1; data_in = 8'h11;
        step();
        check("basic_empty_fall", empty, 0);
        data_in = 8'h22; step();
        data_in = 8'h33; step();
        write = 1'b0;
        read = 1'b1;
        step(); check("basic_rd0", data_out, 8'h11);
        step(); check("basic_rd1", data_out, 8'h22);
        check("basic_not_empty", empty, 0);
        step(); check("basic_rd2", data_out, 8'h33);
        check("basic_empty", empty, 1);
        read = 1'b0;

        // Enable gating from a fresh FIFO
        do_reset();
        enable = 1'b0;
        write = 1'b1; data_in = 8'h5A;
        for (int i = 0; i < 50; i++) step();
        check("gate_empty_w", empty, 1);
        write = 1'b0; read = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("gate_empty_r", empty, 1);
        check("gate_dout", data_out, 8'h00);
        read = 1'b0;

        // Fill to full, overflow, drain with wrap
        enable = 1'b1;
        write = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            data_in = DW'(i);
            if (i == DEPTH - 1) check("full_before_last", full, 0);
            step();
        end
        check("full_set", full, 1);
        check("full_not_empty", empty, 0);
        data_in = 8'hAA;
        step();
        check("ovf_full", full, 1);
        write = 1'b0;
        read = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            if (data_out !== DW'(i)) bad_reads++;
            if (i == 0) check("full_fall", full, 0);
        end
        check("drain_bad_reads", bad_reads, 0);
        check("drain_last", data_out, 8'hFF);
        check("drain_empty", empty, 1);

        // Underflow holds data_out
        for (int i = 0; i < 3; i++) step();
        check("udf_dout", data_out, 8'hFF);
        check("udf_empty", empty, 1);
        read = 1'b0;

        // Simultaneous read/write with five words queued
        write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h50 + 8'(i);
            step();
        end
        read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 8'h60 + 8'(i);
            step();
            check("sim_dout", data_out, (i < 5) ? 32'h50 + i : 32'h60 + (i - 5));
            check("sim_empty", empty, 0);
        end
        write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("sim_drain", data_out, 32'h65 + i);
            check("sim_drain_empty", empty, (i == 4) ? 1 : 0);
        end

        // Read+write on empty: write lands, read dropped
        write = 1'b1; read = 1'b1; data_in = 8'h77;
        step();
        check("er_dout_hold", data_out, 8'h69);
        check("er_empty", empty, 0);
        write = 1'b0;
        step();
        check("er_rd", data_out, 8'h77);
        check("er_empty2", empty, 1);
        read = 1'b0;

        // Mid-operation asynchronous reset
        write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_in = 8'hB0 + 8'(i);
            step();
        end
        write = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mrst_empty", empty, 1);
        check("mrst_dout", data_out, 8'h00);
        check("mrst_full", full, 0);
        step();
        reset = 1'b1;
        write = 1'b1; data_in = 8'hC3;
        step();
        write = 1'b0; read = 1'b1;
        step();
        check("mrst_new_data", data_out, 8'hC3);
        check("mrst_new_empty", empty, 1);
        read = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fifo_ram
